pythagora_norm_seq: RTL and testbench

// - Sequential N-dimensional Euclidean norm: hyp = floor(sqrt(sum of in_vec[i]^2)), plus remainder and exact flag.
// - Successor to the 2-input hypotenuse datapath, generalised in width and dimension count.
// - Accumulator is sized so it cannot overflow. Valid/ready handshake on both sides. Back-pressure safe.
// - Sits between a vector producer and any downstream consumer in the pythagora subsystem.

---
 rtl/pythagora_pkg.sv | 22 ++
 rtl/norm_isqrt_seq.sv | 70 +++++++
 rtl/pythagora_norm_seq.sv | 132 +++++++++++++
 tb/tb_pythagora_norm_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pythagora_pkg.sv
// Shared types and width helpers for the pythagora norm datapath.
// Keeps width derivation in one place so sub-blocks agree on sizes.
package pythagora_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_SQRT = 2'd2,
        ST_DONE = 2'd3
    } norm_state_e;

    // Accumulator width that holds ndim squares of dw-bit values.
    function automatic int norm_aw(input int dw, input int ndim);
        return 2 * dw + $clog2(ndim);
    endfunction

    // Root width for an aw-bit radicand.
    function automatic int norm_rw(input int aw);
        return (aw + 1) / 2;
    endfunction

endpackage

// File: rtl/norm_isqrt_seq.sv
// Iterative radix-4 integer square root, one root bit per cycle.
// root/rem carry the final result during the cycle done is high.
module norm_isqrt_seq
    import pythagora_pkg::*;
#(
    parameter  int AW = 33,
    localparam int RW = norm_rw(AW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] radicand,
    output logic          done,
    output logic [RW-1:0] root,
    output logic [RW:0]   rem
);

    localparam int PW = 2 * RW;
    localparam int CW = $clog2(RW + 1);

    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_rad;
    logic [RW-1:0] r_root;
    logic [RW:0]   r_rem;

    logic [RW+2:0] w_rem_sh;
    logic [RW+2:0] w_trial;
    logic          w_ge;
    logic [RW-1:0] w_root_nxt;
    logic [RW:0]   w_rem_nxt;

    // Bring down the next radicand digit pair and try setting a root bit.
    // The partial remainder never exceeds 2*root, so RW+1 bits hold it.
    always_comb begin
        w_rem_sh   = {r_rem, r_rad[PW-1 -: 2]};
        w_trial    = {1'b0, r_root, 2'b01};
        w_ge       = (w_rem_sh >= w_trial);
        w_root_nxt = RW'({r_root, w_ge});
        w_rem_nxt  = (RW + 1)'(w_ge ? w_rem_sh - w_trial : w_rem_sh);
    end

    assign done = r_busy && (r_cnt == CW'(1));
    assign root = w_root_nxt;
    assign rem  = w_rem_nxt;

    // Load on start, then iterate exactly RW times MSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_rad  <= '0;
            r_root <= '0;
            r_rem  <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= CW'(RW);
            r_rad  <= PW'(radicand);
            r_root <= '0;
            r_rem  <= '0;
        end else if (r_busy) begin
            r_rad  <= r_rad << 2;
            r_root <= w_root_nxt;
            r_rem  <= w_rem_nxt;
            r_cnt  <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/pythagora_norm_seq.sv
// Sequential N-dimensional Euclidean norm with remainder and exact flag.
// One shared squarer accumulates elements, then an iterative sqrt runs.
module pythagora_norm_seq
    import pythagora_pkg::*;
#(
    parameter  int DW   = 16,
    parameter  int NDIM = 2,
    localparam int AW   = norm_aw(DW, NDIM),
    localparam int RW   = norm_rw(AW)
) (
    input  logic              py_clock,
    input  logic              py_rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NDIM*DW-1:0] in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RW-1:0]     out_hyp,
    output logic [RW:0]       out_rem,
    output logic              out_exact,
    output logic              busy
);

    localparam int IW = (NDIM > 1) ? $clog2(NDIM) : 1;

    norm_state_e      r_state;
    logic [NDIM*DW-1:0] r_vec;
    logic [AW-1:0]    r_acc;
    logic [IW-1:0]    r_idx;
    logic [RW-1:0]    r_hyp;
    logic [RW:0]      r_rem;
    logic             r_exact;

    logic [DW-1:0]    w_elem;
    logic [2*DW-1:0]  w_elem_x;
    logic [2*DW-1:0]  w_sq;
    logic [AW-1:0]    w_acc_nxt;
    logic             w_last;
    logic             w_accept;
    logic             w_sq_start;
    logic             w_sq_done;
    logic [RW-1:0]    w_root;
    logic [RW:0]      w_rem;

    // Select the current element from the latched vector.
    always_comb begin
        w_elem = '0;
        for (int i = 0; i < NDIM; i++) begin
            if (r_idx == IW'(i)) w_elem = r_vec[i*DW +: DW];
        end
    end

    assign w_elem_x   = {{DW{1'b0}}, w_elem};
    assign w_sq       = w_elem_x * w_elem_x;
    assign w_acc_nxt  = r_acc + AW'(w_sq);
    assign w_last     = (r_idx == IW'(NDIM - 1));

    assign in_ready   = (r_state == ST_IDLE) ||
                        ((r_state == ST_DONE) && out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_sq_start = (r_state == ST_ACC) && w_last;

    assign out_valid  = (r_state == ST_DONE);
    assign busy       = (r_state == ST_ACC) || (r_state == ST_SQRT);
    assign out_hyp    = r_hyp;
    assign out_rem    = r_rem;
    assign out_exact  = r_exact;

    // The sqrt starts on the final sum, including the last square.
    norm_isqrt_seq #(
        .AW (AW)
    ) u_isqrt (
        .clk      (py_clock),
        .rst_n    (py_rst_n),
        .start    (w_sq_start),
        .radicand (w_acc_nxt),
        .done     (w_sq_done),
        .root     (w_root),
        .rem      (w_rem)
    );

    // Control FSM, accumulator and result registers.
    always_ff @(posedge py_clock or negedge py_rst_n) begin
        if (!py_rst_n) begin
            r_state <= ST_IDLE;
            r_vec   <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_hyp   <= '0;
            r_rem   <= '0;
            r_exact <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_vec   <= in_vec;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    r_acc <= w_acc_nxt;
                    r_idx <= r_idx + IW'(1);
                    if (w_last) r_state <= ST_SQRT;
                end
                ST_SQRT: begin
                    if (w_sq_done) begin
                        r_hyp   <= w_root;
                        r_rem   <= w_rem;
                        r_exact <= (w_rem == '0);
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            r_vec   <= in_vec;
                            r_acc   <= '0;
                            r_idx   <= '0;
                            r_state <= ST_ACC;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pythagora_norm_seq.sv
// Scoreboard bench for pythagora_norm_seq (NDIM=2 and NDIM=3 instances).
// Stimulus pushes expected results; monitors pop on each retired output.
module tb_pythagora_norm_seq;

    typedef struct packed {
        logic [16:0] hyp;
        logic [17:0] rem;
        logic        exact;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_hyp;
    logic [17:0] out_rem;
    logic        out_exact;
    logic        busy;

    logic        in_valid3;
    logic        in_ready3;
    logic [47:0] in_vec3;
    logic        out_valid3;
    logic [16:0] out_hyp3;
    logic [17:0] out_rem3;
    logic        out_exact3;
    logic        busy3;

    int   checks;
    int   failures;
    int   sent;
    int   got;
    bit   rand_mode;
    bit   ready_dir;
    exp_t q[$];
    exp_t q3[$];

    pythagora_norm_seq #(.DW(16), .NDIM(2)) dut (
        .py_clock  (clk),
        .py_rst_n  (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hyp   (out_hyp),
        .out_rem   (out_rem),
        .out_exact (out_exact),
        .busy      (busy)
    );

    pythagora_norm_seq #(.DW(16), .NDIM(3)) dut3 (
        .py_clock  (clk),
        .py_rst_n  (rst_n),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_vec    (in_vec3),
        .out_valid (out_valid3),
        .out_ready (1'b1),
        .out_hyp   (out_hyp3),
        .out_rem   (out_rem3),
        .out_exact (out_exact3),
        .busy      (busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input longint act,
                       input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference floor-sqrt by bitwise trial squaring.
    function automatic exp_t model(input longint unsigned s);
        exp_t e;
        longint unsigned r;
        longint unsigned t;
        r = 0;
        for (int b = 17; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= s) r = t;
        end
        e.hyp   = 17'(r);
        e.rem   = 18'(s - r * r);
        e.exact = (s == r * r);
        return e;
    endfunction

    task automatic send(input logic [31:0] v, input exp_t e);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            in_valid = 1'b1;
            in_vec   = v;
            #1;
            if (in_ready) begin
                q.push_back(e);
                sent++;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_vec   = $urandom;
                return;
            end
            n++;
            if (n > 300) begin
                chk("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic send3(input logic [47:0] v, input exp_t e);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            in_valid3 = 1'b1;
            in_vec3   = v;
            #1;
            if (in_ready3) begin
                q3.push_back(e);
                @(posedge clk);
                #1;
                in_valid3 = 1'b0;
                return;
            end
            n++;
            if (n > 300) begin
                chk("accept3_timeout", 0, 1);
                in_valid3 = 1'b0;
                return;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || q3.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) chk("drain_timeout", q.size() + q3.size(), 0);
    endtask

    // Consumer ready: directed value or random back-pressure.
    always @(negedge clk) begin
        if (rand_mode) out_ready = 1'($urandom_range(0, 1));
        else           out_ready = ready_dir;
    end

    // Main monitor: stability while stalled, scoreboard pop on retire.
    initial begin
        exp_t e;
        logic [35:0] prev;
        bit hold;
        hold = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                hold = 1'b0;
                continue;
            end
            if (out_valid) begin
                if (hold) chk("stable", {out_hyp, out_rem, out_exact}, prev);
                if (out_ready) begin
                    hold = 1'b0;
                    got++;
                    if (q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("hyp", out_hyp, e.hyp);
                        chk("rem", out_rem, e.rem);
                        chk("exact", out_exact, e.exact);
                    end
                end else begin
                    hold = 1'b1;
                    prev = {out_hyp, out_rem, out_exact};
                end
            end else begin
                hold = 1'b0;
            end
        end
    end

    // NDIM=3 monitor; its consumer is always ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid3) begin
                if (q3.size() == 0) begin
                    chk("unexpected_result3", 1, 0);
                end else begin
                    e = q3.pop_front();
                    chk("hyp3", out_hyp3, e.hyp);
                    chk("rem3", out_rem3, e.rem);
                    chk("exact3", out_exact3, e.exact);
                end
            end
        end
    end

    initial begin
        int n;
        logic [15:0] a;
        logic [15:0] b;
        longint unsigned s;
        checks    = 0;
        failures  = 0;
        sent      = 0;
        got       = 0;
        rand_mode = 1'b0;
        ready_dir = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        in_valid3 = 1'b0;
        in_vec3   = '0;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hyp", out_hyp, 0);
        chk("rst_rem", out_rem, 0);
        chk("rst_exact", out_exact, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // (3,4) -> 5, with exact latency.
        ready_dir = 1'b1;
        send({16'd4, 16'd3}, exp_t'{17'd5, 18'd0, 1'b1});
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 40);
        chk("latency", n, 19);

        // Largest inputs: no overflow.
        send({16'hFFFF, 16'hFFFF}, exp_t'{17'd92680, 18'd90050, 1'b0});

        // NDIM=3 vectors.
        send3({16'd6, 16'd3, 16'd2}, exp_t'{17'd7, 18'd0, 1'b1});
        send3({16'd0, 16'd1, 16'd1}, exp_t'{17'd1, 18'd1, 1'b0});
        drain();

        // Back-pressure then same-cycle retire and accept.
        ready_dir = 1'b0;
        send({16'd12, 16'd5}, exp_t'{17'd13, 18'd0, 1'b1});
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_wait_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
        end
        ready_dir = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_vec   = {16'd8, 16'd6};
        #1;
        chk("bp_in_ready_retire", in_ready, 1);
        q.push_back(exp_t'{17'd10, 18'd0, 1'b1});
        sent++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_busy_next", busy, 1);
        chk("bp_valid_next", out_valid, 0);
        drain();

        // Asynchronous reset in the middle of the sqrt phase.
        send({16'd4, 16'd3}, exp_t'{17'd5, 18'd0, 1'b1});
        repeat (4) @(posedge clk);
        #3;
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_hyp", out_hyp, 0);
        chk("mid_rst_rem", out_rem, 0);
        chk("mid_rst_exact", out_exact, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        sent -= q.size();
        q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        send({16'd0, 16'd0}, exp_t'{17'd0, 18'd0, 1'b1});
        drain();

        // Random vectors with random gaps and back-pressure.
        rand_mode = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            unique case (k % 4)
                0: begin a = 16'($urandom); b = 16'($urandom); end
                1: begin
                    a = 16'($urandom_range(0, 15));
                    b = 16'($urandom_range(0, 15));
                end
                2: begin
                    a = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0;
                    b = 16'($urandom);
                end
                default: begin
                    a = 16'($urandom_range(0, 300));
                    b = 16'($urandom);
                end
            endcase
            s = longint'(a) * longint'(a) + longint'(b) * longint'(b);
            send({b, a}, model(s));
        end
        drain();
        rand_mode = 1'b0;
        chk("result_count", got, sent);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
